legv8_multicycle_control: RTL

Main control FSM for the multicycle LEGv8 datapath. It sits directly upstream of the ALU control unit, decodes the 11-bit instruction opcode and sequences fetch, decode, execute, memory and writeback. It drives datapath enables and the 2-bit ALUOp consumed by the ALU control unit. It stalls on a memory-ready handshake.

---
 rtl/legv8_pkg.sv | 54 +++++
 rtl/legv8_opcode_class.sv | 37 +++
 rtl/legv8_multicycle_control.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// -----------------------------------------------------------------------------
// legv8_pkg
// Shared definitions for the multicycle LEGv8 main control unit:
//   - state_t     : FSM state encoding (also exported on the State debug port)
//   - OP_*        : opcode match constants (full 11-bit, CBZ 8-bit, B 6-bit)
//   - ALUOP_*     : 2-bit ALUOp codes consumed by the ALU control unit
//   - SRCB_*      : ALUSrcB mux selects
//   - op_class_t  : one-hot instruction class produced by legv8_opcode_class
// -----------------------------------------------------------------------------
package legv8_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_LOAD_WB   = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_R_WB      = 4'd7,
    S_CBZ       = 4'd8,
    S_BRANCH    = 4'd9,
    S_ILLEGAL   = 4'd10
  } state_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ8 = 8'b10110100;   // matched against Opcode[10:3]
  localparam logic [5:0]  OP_B6   = 6'b000101;     // matched against Opcode[10:5]

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_ADDR   = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // Exactly one bit is set for any opcode.
  typedef struct packed {
    logic b;
    logic cbz;
    logic ldur;
    logic stur;
    logic rtype;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/legv8_opcode_class.sv
// -----------------------------------------------------------------------------
// legv8_opcode_class
// Combinational classifier: maps the 11-bit opcode field to a one-hot class.
// Matching is prioritised B > CBZ > LDUR > STUR > R-type, so the short-prefix
// B and CBZ patterns win even if a longer pattern would also match.
// Ports:
//   opcode   in  [10:0]      instruction bits [31:21]
//   op_class out op_class_t  one-hot class (illegal when nothing matches)
// -----------------------------------------------------------------------------
module legv8_opcode_class
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class
);

  always_comb begin
    // NOTE: the whole struct is defaulted before the if-chain so every path
    // assigns every bit; a missing default here would infer a latch.
    op_class = '0;
    if (opcode[10:5] == OP_B6) begin
      op_class.b = 1'b1;
    end else if (opcode[10:3] == OP_CBZ8) begin
      op_class.cbz = 1'b1;
    end else if (opcode == OP_LDUR) begin
      op_class.ldur = 1'b1;
    end else if (opcode == OP_STUR) begin
      op_class.stur = 1'b1;
    end else if (opcode == OP_ADD || opcode == OP_SUB ||
                 opcode == OP_AND || opcode == OP_ORR) begin
      op_class.rtype = 1'b1;
    end else begin
      op_class.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/legv8_multicycle_control.sv
// -----------------------------------------------------------------------------
// legv8_multicycle_control
// Main control FSM of the multicycle LEGv8 datapath. Sequences fetch, decode,
// execute, memory and writeback, stalling in FETCH/MEM_READ/MEM_WRITE until
// MemReady. Unknown opcodes (or a memory wait timeout) park the FSM in a
// sticky ILLEGAL state that only Reset leaves.
//
// Parameter:
//   MEM_WAIT_MAX  0 = wait on MemReady forever; N > 0 = after N consecutive
//                 MemReady-low cycles in a wait state, go to ILLEGAL.
// Optional build macro:
//   LEGV8_PERF_COUNT_EN  adds CycleCount / InstrCount 32-bit outputs.
//
// Ports:
//   CLK, Reset (async, active-low)
//   Opcode[10:0], Zero, MemReady               inputs
//   PCWrite, IorD, MemRead, MemWrite, IRWrite  datapath/memory enables
//   MemToReg, RegWrite, Reg2Loc                register file controls
//   ALUSrcA, ALUSrcB[1:0], ALUOp[1:0]          ALU operand/op selects
//   PCSource                                   PC mux select
//   State[3:0], IllegalOp                      debug / status
//   CycleCount[31:0], InstrCount[31:0]         (LEGV8_PERF_COUNT_EN only)
// -----------------------------------------------------------------------------
module legv8_multicycle_control
  import legv8_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 0
)
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic [10:0] Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        Reg2Loc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        PCSource,
  output logic [3:0]  State,
  output logic        IllegalOp
`ifdef LEGV8_PERF_COUNT_EN
  ,
  output logic [31:0] CycleCount,
  output logic [31:0] InstrCount
`endif
);

  localparam int WAIT_W = (MEM_WAIT_MAX < 16) ? 4 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_t            state;
  state_t            next_state;
  op_class_t         cls;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_state;
  logic              timeout;

  legv8_opcode_class u_opcode_class (
    .opcode   (Opcode),
    .op_class (cls)
  );

  assign State      = state;
  assign wait_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);

  // Counts consecutive stalled cycles; any cycle outside a wait state or with
  // MemReady high clears it, which covers every entry into a wait state.
  assign timeout = (MEM_WAIT_MAX != 0) && wait_state && !MemReady && (wait_cnt == WAIT_LAST);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wait_cnt <= '0;
    end else if ((MEM_WAIT_MAX != 0) && wait_state && !MemReady) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    if (!Reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    Reg2Loc    = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ALUOp      = ALUOP_ADD;
    PCSource   = 1'b0;
    IllegalOp  = 1'b0;

    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        // Reset gating keeps PC/IR from loading while reset is held in FETCH.
        IRWrite = MemReady & Reset;
        PCWrite = MemReady & Reset;
        if (timeout)       next_state = S_ILLEGAL;
        else if (MemReady) next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_BRANCH;
        Reg2Loc = cls.stur | cls.cbz;
        if (cls.illegal)                next_state = S_ILLEGAL;
        else if (cls.ldur || cls.stur)  next_state = S_MEM_ADDR;
        else if (cls.rtype)             next_state = S_EXEC;
        else if (cls.cbz)               next_state = S_CBZ;
        else                            next_state = S_BRANCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_ADDR;
        if (cls.ldur)      next_state = S_MEM_READ;
        else if (cls.stur) next_state = S_MEM_WRITE;
        else               next_state = S_ILLEGAL;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (timeout)       next_state = S_ILLEGAL;
        else if (MemReady) next_state = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Reg2Loc  = 1'b1;
        if (timeout)       next_state = S_ILLEGAL;
        else if (MemReady) next_state = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOP_RTYPE;
        next_state = S_R_WB;
      end
      S_R_WB: begin
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_CBZ: begin
        Reg2Loc    = 1'b1;
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOP_PASSB;
        PCSource   = 1'b1;
        PCWrite    = Zero;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        PCSource   = 1'b1;
        PCWrite    = 1'b1;
        next_state = S_FETCH;
      end
      S_ILLEGAL: begin
        IllegalOp = 1'b1;
      end
      default: begin
        // Unused encodings are treated as a fault.
        next_state = S_ILLEGAL;
      end
    endcase
  end

`ifdef LEGV8_PERF_COUNT_EN
  logic instr_done;

  assign instr_done = (next_state == S_FETCH) &&
                      ((state == S_LOAD_WB) || (state == S_MEM_WRITE) ||
                       (state == S_R_WB) || (state == S_CBZ) || (state == S_BRANCH));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      CycleCount <= '0;
      InstrCount <= '0;
    end else if (state != S_ILLEGAL) begin
      CycleCount <= CycleCount + 32'd1;
      if (instr_done) InstrCount <= InstrCount + 32'd1;
    end
  end
`endif

endmodule
